uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_frame_decoder.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame decoder.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - byte offsets of the fixed frame fields
//   - default SYNC / ACK / NAK marker bytes
//   - saturating increment helper for the 16-bit error counter
package uart_pkg;

  // Decoder FSM states
  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAY     = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_DELIVER = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;

  // Frame layout: SYNC, CMD, LEN, payload[LEN], CHK
  localparam int OFS_SYNC = 0;
  localparam int OFS_CMD  = 1;
  localparam int OFS_LEN  = 2;
  localparam int OFS_PAY  = 3;

  // Default marker bytes
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NAK_DEFAULT  = 8'h15;

  // Total on-the-wire byte count of a frame carrying len payload bytes.
  function automatic int frame_bytes(input int len);
    return (OFS_PAY - OFS_SYNC) + len + (OFS_LEN - OFS_CMD);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_frame_decoder.sv
// UART command-frame decoder.
// Pops bytes from a show-ahead RX queue, hunts for SYNC, collects
// CMD/LEN/payload/CHK, presents good frames on a valid/ready port and
// answers every completed frame with one ACK or NAK byte pushed into the
// TX queue. An inter-byte gap timer abandons stalled frames silently.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rxq_data/_empty   RX queue head byte and empty flag (uart rx queue outputs)
//   o_deq_rxq           pop RX queue head this edge
//   o_enq_txq/o_txq_data push ACK/NAK byte into TX queue (uart tx queue inputs)
//   i_txq_full          TX queue cannot accept
//   o_frm_valid/i_frm_ready  decoded-frame handshake
//   o_frm_cmd/_len/_payload  decoded frame fields (byte k at [8k+7:8k])
//   o_err_cnt           saturating count of rejected frames
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    MAX_LEN     = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE   = DATA_WIDTH'(SYNC_DEFAULT),
  parameter int                    TIMEOUT_CYC = 100000,
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE    = DATA_WIDTH'(ACK_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] NAK_BYTE    = DATA_WIDTH'(NAK_DEFAULT)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [DATA_WIDTH-1:0]      i_rxq_data,
  input  logic                       i_rxq_empty,
  output logic                       o_deq_rxq,
  output logic                       o_enq_txq,
  output logic [DATA_WIDTH-1:0]      o_txq_data,
  input  logic                       i_txq_full,
  output logic                       o_frm_valid,
  input  logic                       i_frm_ready,
  output logic [7:0]                 o_frm_cmd,
  output logic [$clog2(MAX_LEN+1)-1:0] o_frm_len,
  output logic [MAX_LEN*8-1:0]       o_frm_payload,
  output logic [15:0]                o_err_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_D = DATA_WIDTH'(MAX_LEN);

  logic [2:0]            state;
  logic [7:0]            cmd_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] chk_q;
  logic [MAX_LEN*8-1:0]  payload_q;
  logic [GAP_W-1:0]      gap_q;
  logic [15:0]           err_q;
  logic [DATA_WIDTH-1:0] resp_q;

  logic in_frame;
  logic pop;

  // The gap timer only runs while a frame is partially received.
  assign in_frame = (state == ST_CMD) || (state == ST_LEN) ||
                    (state == ST_PAY) || (state == ST_CHK);

  // Gated by reset so nothing is consumed while the block is held in reset.
  assign pop       = !i_rst && !i_rxq_empty && ((state == ST_HUNT) || in_frame);
  assign o_deq_rxq = pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_HUNT;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      payload_q <= '0;
      gap_q     <= '0;
      err_q     <= '0;
      resp_q    <= '0;
    end else begin
      // Inter-byte gap timer: cleared by any pop, expiry drops the frame
      // without a response.
      if (in_frame && !pop) begin
        if (gap_q == GAP_LAST) begin
          gap_q <= '0;
          state <= ST_HUNT;
          err_q <= sat_inc16(err_q);
        end else begin
          gap_q <= gap_q + GAP_W'(1);
        end
      end

      if (pop) begin
        gap_q <= '0;
        case (state)
          ST_HUNT: begin
            if (i_rxq_data == SYNC_BYTE) state <= ST_CMD;
          end
          ST_CMD: begin
            cmd_q <= i_rxq_data[7:0];
            chk_q <= i_rxq_data;
            state <= ST_LEN;
          end
          ST_LEN: begin
            chk_q <= chk_q ^ i_rxq_data;
            if (i_rxq_data == '0) begin
              len_q <= '0;
              state <= ST_CHK;
            end else if (i_rxq_data <= MAX_LEN_D) begin
              len_q <= LEN_W'(i_rxq_data);
              idx_q <= '0;
              state <= ST_PAY;
            end else begin
              // Oversized frame is refused up front; its body is then hunted
              // through as garbage.
              resp_q <= NAK_BYTE;
              err_q  <= sat_inc16(err_q);
              state  <= ST_RESP;
            end
          end
          ST_PAY: begin
            // SYNC bytes here are ordinary payload; there is no resync.
            payload_q[idx_q*8 +: 8] <= i_rxq_data[7:0];
            chk_q <= chk_q ^ i_rxq_data;
            if (idx_q == len_q - LEN_W'(1)) state <= ST_CHK;
            else                            idx_q <= idx_q + LEN_W'(1);
          end
          ST_CHK: begin
            if (i_rxq_data == chk_q) begin
              state <= ST_DELIVER;
            end else begin
              resp_q <= NAK_BYTE;
              err_q  <= sat_inc16(err_q);
              state  <= ST_RESP;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end else begin
        case (state)
          ST_DELIVER: begin
            if (i_frm_ready) begin
              resp_q <= ACK_BYTE;
              state  <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (!i_txq_full) state <= ST_HUNT;
          end
          ST_HUNT, ST_CMD, ST_LEN, ST_PAY, ST_CHK: ;
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign o_frm_valid   = (state == ST_DELIVER);
  assign o_enq_txq     = (state == ST_RESP) && !i_txq_full;
  assign o_txq_data    = (state == ST_RESP) ? resp_q : '0;
  assign o_frm_cmd     = cmd_q;
  assign o_frm_len     = len_q;
  assign o_frm_payload = payload_q;
  assign o_err_cnt     = err_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: directed byte streams are fed
// through a show-ahead RX queue model; expected frames and TX bytes are
// queued at stimulus time and checked by an independent monitor.
module tb_uart_frame_decoder;

  localparam int TMO = 40;

  typedef struct packed {
    logic [7:0]   cmd;
    logic [4:0]   len;
    logic [127:0] pay;
  } frm_t;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [7:0]   i_rxq_data;
  logic         i_rxq_empty;
  logic         o_deq_rxq;
  logic         o_enq_txq;
  logic [7:0]   o_txq_data;
  logic         i_txq_full = 1'b0;
  logic         o_frm_valid;
  logic         i_frm_ready = 1'b1;
  logic [7:0]   o_frm_cmd;
  logic [4:0]   o_frm_len;
  logic [127:0] o_frm_payload;
  logic [15:0]  o_err_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0]   rxq[$];
  logic [7:0]   exp_tx[$];
  frm_t         exp_frm[$];
  logic [127:0] pay_model = '0;
  logic [15:0]  err_model = '0;

  uart_frame_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rxq_data(i_rxq_data), .i_rxq_empty(i_rxq_empty), .o_deq_rxq(o_deq_rxq),
    .o_enq_txq(o_enq_txq), .o_txq_data(o_txq_data), .i_txq_full(i_txq_full),
    .o_frm_valid(o_frm_valid), .i_frm_ready(i_frm_ready),
    .o_frm_cmd(o_frm_cmd), .o_frm_len(o_frm_len), .o_frm_payload(o_frm_payload),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Show-ahead RX queue model: pop sampled at the edge, head refreshed just after.
  initial begin
    logic deq_s;
    i_rxq_empty = 1'b1;
    i_rxq_data  = '0;
    forever begin
      @(posedge i_clk);
      deq_s = o_deq_rxq;
      #1;
      if (deq_s && rxq.size() > 0) void'(rxq.pop_front());
      i_rxq_empty = (rxq.size() == 0);
      i_rxq_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end
  end

  // Monitor: compares every TX push and every frame handshake against the scoreboard.
  initial begin
    frm_t f;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_enq_txq) begin
          if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_tx: got %h, expected no TX byte", o_txq_data);
          end else begin
            check("tx_byte", {120'd0, o_txq_data}, {120'd0, exp_tx.pop_front()});
          end
        end
        if (o_frm_valid && i_frm_ready) begin
          if (exp_frm.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_frame: got cmd %h len %0d, expected no frame", o_frm_cmd, o_frm_len);
          end else begin
            f = exp_frm.pop_front();
            check("frm_cmd", {120'd0, o_frm_cmd}, {120'd0, f.cmd});
            check("frm_len", {123'd0, o_frm_len}, {123'd0, f.len});
            check("frm_payload", o_frm_payload, f.pay);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push(input logic [7:0] bs[$]);
    foreach (bs[i]) rxq.push_back(bs[i]);
  endtask

  task automatic expect_ack(input logic [7:0] cmd, input logic [4:0] len);
    frm_t f;
    f.cmd = cmd; f.len = len; f.pay = pay_model;
    exp_frm.push_back(f);
    exp_tx.push_back(8'h06);
  endtask

  task automatic expect_nak();
    exp_tx.push_back(8'h15);
    err_model++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((rxq.size() != 0 || exp_tx.size() != 0 || exp_frm.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s_timeout: got rx=%0d tx=%0d frm=%0d pending, expected 0", name,
               rxq.size(), exp_tx.size(), exp_frm.size());
    end
    repeat (3) tick();
    check({name, "_err_cnt"}, {112'd0, o_err_cnt}, {112'd0, err_model});
  endtask

  initial begin
    int busy;
    int vcnt;
    int n;

    // Reset state
    @(negedge i_clk);
    check("rst_valid", {127'd0, o_frm_valid}, 128'd0);
    check("rst_deq", {127'd0, o_deq_rxq}, 128'd0);
    check("rst_enq", {127'd0, o_enq_txq}, 128'd0);
    check("rst_err", {112'd0, o_err_cnt}, 128'd0);
    check("rst_payload", o_frm_payload, 128'd0);
    tick();
    i_rst = 1'b0;
    tick();

    // Maximum length frame: cmd 11, len 16, payload 00..0F; chk = 11^10^00 = 01
    push('{8'hA5, 8'h11, 8'h10});
    for (int k = 0; k < 16; k++) begin
      rxq.push_back(8'(k));
      pay_model[k*8 +: 8] = 8'(k);
    end
    push('{8'h01});
    expect_ack(8'h11, 5'd16);
    wait_idle("maxlen");

    // Two-byte frame; chk = 10^02^AA^55 = ED; bytes 2..15 keep prior contents
    push('{8'hA5, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hED});
    pay_model[7:0] = 8'hAA; pay_model[15:8] = 8'h55;
    expect_ack(8'h10, 5'd2);
    wait_idle("len2");

    // Bad checksum (expected 22) -> NAK
    push('{8'hA5, 8'h10, 8'h01, 8'h33, 8'h00});
    pay_model[7:0] = 8'h33;
    expect_nak();
    wait_idle("badchk");

    // Leading garbage, zero-length frame; chk = 20^00 = 20
    push('{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h20});
    expect_ack(8'h20, 5'd0);
    wait_idle("len0");

    // LEN=17 -> immediate NAK, rest hunted until next SYNC
    push('{8'hA5, 8'h10, 8'h11, 8'h44, 8'h55, 8'hA5, 8'h20, 8'h00, 8'h20});
    expect_nak();
    expect_ack(8'h20, 5'd0);
    wait_idle("oversize");

    // Gap timeout: no response, error counted, decoder back in HUNT
    push('{8'hA5, 8'h10});
    n = 0;
    while (rxq.size() != 0 && n < 100) begin tick(); n++; end
    repeat (TMO + 20) tick();
    err_model++;
    check("timeout_err", {112'd0, o_err_cnt}, {112'd0, err_model});
    push('{8'hA5, 8'h20, 8'h00, 8'h20});
    expect_ack(8'h20, 5'd0);
    wait_idle("after_timeout");

    // SYNC byte inside payload is data; chk = 40^02^A5^01 = E6
    push('{8'hA5, 8'h40, 8'h02, 8'hA5, 8'h01, 8'hE6});
    pay_model[7:0] = 8'hA5; pay_model[15:8] = 8'h01;
    expect_ack(8'h40, 5'd2);
    wait_idle("midsync");

    // Backpressure on both frame and TX ports; chk = 30^01^7E = 4F
    i_frm_ready = 1'b0;
    i_txq_full  = 1'b1;
    push('{8'hA5, 8'h30, 8'h01, 8'h7E, 8'h4F, 8'hA5, 8'h20, 8'h00, 8'h20});
    pay_model[7:0] = 8'h7E;
    expect_ack(8'h30, 5'd1);
    expect_ack(8'h20, 5'd0);
    n = 0;
    while (!o_frm_valid && n < 100) begin tick(); n++; end
    check("bp_valid_rise", {127'd0, o_frm_valid}, 128'd1);
    busy = 0; vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_deq_rxq || o_enq_txq) busy++;
      if (o_frm_valid) vcnt++;
    end
    check("bp_deliver_stall", 128'(busy), 128'd0);
    check("bp_valid_held", 128'(vcnt), 128'd10);
    i_frm_ready = 1'b1;
    tick();
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_deq_rxq || o_enq_txq) busy++;
    end
    check("bp_resp_stall", 128'(busy), 128'd0);
    check("bp_rx_untouched", 128'(rxq.size()), 128'd4);
    i_txq_full = 1'b0;
    wait_idle("backpressure");

    // Reset in the middle of a payload: frame abandoned, outputs cleared
    push('{8'hA5, 8'h50, 8'h04, 8'h11, 8'h22});
    n = 0;
    while (rxq.size() != 0 && n < 100) begin tick(); n++; end
    tick();
    i_rst = 1'b1;
    push('{8'h77});
    tick();
    check("midrst_deq", {127'd0, o_deq_rxq}, 128'd0);
    check("midrst_valid", {127'd0, o_frm_valid}, 128'd0);
    check("midrst_enq", {127'd0, o_enq_txq}, 128'd0);
    check("midrst_txdata", {120'd0, o_txq_data}, 128'd0);
    check("midrst_err", {112'd0, o_err_cnt}, 128'd0);
    check("midrst_cmd_len", {115'd0, o_frm_cmd, o_frm_len}, 128'd0);
    check("midrst_payload", o_frm_payload, 128'd0);
    i_rst = 1'b0;
    pay_model = '0;
    err_model = '0;

    // Clean frame after reset; chk = 60^01^99 = F8 (stray 77 is hunted away)
    push('{8'hA5, 8'h60, 8'h01, 8'h99, 8'hF8});
    pay_model[7:0] = 8'h99;
    expect_ack(8'h60, 5'd1);
    wait_idle("post_reset");

    check("leftover_tx", 128'(exp_tx.size()), 128'd0);
    check("leftover_frm", 128'(exp_frm.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
